idu_hazard_ctrl: RTL and testbench
==================================

Name: idu_hazard_ctrl

Overview:
Pipeline hazard controller driving the stall/flush control bus of the ID->EX pipeline register.
- Keeps a per-register scoreboard of outstanding long-latency writebacks (load, mul/div).
- Stalls on RAW/WAW hazards, on outstanding-limit and fence conditions, and on EX back-pressure.
- Sequences multi-cycle flushes on redirect.
- Sits in the core between decode, the ID->EX pipe register and the writeback arbiter.

Parameters:
MAX_OUTSTANDING, 4, maximum simultaneously pending long-latency writebacks (1..31).
FLUSH_CYCLES, 2, cycles flush is held after a redirect (1..15).
CNT_W, 5, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous, active-high reset.
id_inst_valid_i  in  1  decode holds a valid instruction.
id_rs1_re_i  in  1  instruction reads rs1.
id_rs1_raddr_i  in  `REG_ADDR_WIDTH  rs1 address.
id_rs2_re_i  in  1  instruction reads rs2.
id_rs2_raddr_i  in  `REG_ADDR_WIDTH  rs2 address.
id_reg_we_i  in  1  instruction writes rd.
id_reg_waddr_i  in  `REG_ADDR_WIDTH  rd address.
id_long_lat_i  in  1  instruction's result returns via the long-latency writeback port.
id_fence_i  in  1  instruction requires all long-latency writebacks drained before issue.
ex_busy_i  in  1  EX cannot accept a new instruction this cycle.
redirect_i  in  1  branch mispredict or trap; kill younger instructions.
wb_valid_i  in  1  long-latency writeback completes this cycle.
wb_waddr_i  in  `REG_ADDR_WIDTH  register completed by that writeback.
stall_flag_o  out  `CU_BUS_WIDTH  control bus to ID->EX pipe; bits `CU_STALL and `CU_FLUSH, others 0.
issue_o  out  1  instruction transferred ID->EX this cycle.
pending_cnt_o  out  CNT_W  number of outstanding long-latency writebacks.
sb_err_o  out  1  sticky; writeback to a non-pending register.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: scoreboard all 0, pending_cnt_o=0, sb_err_o=0, state=RUN, flush counter 0, stall_flag_o=0, issue_o=0.
- Scoreboard: 32 bits; bit 0 (x0) is never set.
- Effective scoreboard: sb_eff = sb & ~(wb_valid_i ? onehot(wb_waddr_i) : 0). This is a same-cycle writeback bypass, so a register completing this cycle never causes a stall.
- Hazard conditions (each valid only when id_inst_valid_i=1):
  - raw = (rs1_re & sb_eff[rs1]) | (rs2_re & sb_eff[rs2]).
  - waw = reg_we & sb_eff[rd].
  - full = long_lat & reg_we & rd!=0 & (cnt_next_base == MAX_OUTSTANDING), where cnt_next_base = pending_cnt minus the same-cycle valid writeback.
  - fence = id_fence_i & (cnt_next_base != 0).
- State RUN:
  - stall = valid & (raw|waw|full|fence|ex_busy_i); flush=0.
  - issue_o = valid & ~stall & ~redirect_i.
- State FLUSH:
  - stall_flag_o[`CU_FLUSH]=1 and [`CU_STALL]=0 every cycle in this state.
  - issue_o=0.
  - The counter loads FLUSH_CYCLES-1 on entry and decrements; return to RUN when it reaches 0.
- Transitions:
  - RUN->FLUSH when redirect_i=1. The flush bit is asserted combinationally in that same cycle, so total flush length is FLUSH_CYCLES.
  - redirect_i while in FLUSH reloads the counter (extends the flush).
  - Flush has priority over stall in all cases; the two bits are never both 1.
- Scoreboard update (registered):
  - On issue_o with long_lat & reg_we & rd!=0: set sb[rd] and increment the counter.
  - On wb_valid_i with sb[wb_waddr] set: clear it and decrement the counter.
  - Both events in the same cycle: the counter nets to unchanged. If they target the same register, the set wins (WAW stall normally prevents this; the bypass permits it).
- Flush does not clear the scoreboard: already-issued long-latency ops still write back.
- wb_valid_i to a register not pending, or to x0: no state change, sb_err_o set (sticky until rst).
- The counter never exceeds MAX_OUTSTANDING and never underflows.
- rst mid-flush or with entries pending returns all state to the reset values next edge.

Test Plan:
1. Issue a load with rd=5 (long_lat), next instruction reads rs1=5 -> stall_flag_o[`CU_STALL]=1 until wb_valid_i with wb_waddr_i=5. Issue in that same cycle, issue_o=1, pending_cnt_o returns 1->0.
2. Issue 4 long-latency ops to x1..x4, then a 5th to x6 with MAX_OUTSTANDING=4 -> stall. A wb to x2 the same cycle lets the 5th issue; pending_cnt_o stays 4.
3. redirect_i pulse for 1 cycle with FLUSH_CYCLES=2 -> `CU_FLUSH high exactly 2 cycles, issue_o=0, `CU_STALL=0 while a RAW hazard is present. A second redirect in cycle 2 extends the flush to 3 cycles total.
4. id_fence_i with 2 pending -> stall until both writebacks complete. Issue occurs in the cycle of the final wb.
5. wb_valid_i to x7 when not pending, and to x0 -> sb_err_o=1 and stays 1, pending_cnt_o unchanged. Long-latency op with rd=0 -> never tracked, pending_cnt_o unchanged.
6. Assert rst during FLUSH with 3 entries pending -> next cycle stall_flag_o=0, pending_cnt_o=0, and a prior-RAW instruction issues immediately.

Source files
------------

// File: rtl/idu_hazard_ctrl_if.sv
// ============================================================================
// idu_hazard_ctrl_if : decode / EX / writeback bundle seen by the hazard ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 4
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif

interface idu_hazard_ctrl_if #(
    parameter int CNT_W = 5
);
    logic                        id_inst_valid_i;
    logic                        id_rs1_re_i;
    logic [`REG_ADDR_WIDTH-1:0]  id_rs1_raddr_i;
    logic                        id_rs2_re_i;
    logic [`REG_ADDR_WIDTH-1:0]  id_rs2_raddr_i;
    logic                        id_reg_we_i;
    logic [`REG_ADDR_WIDTH-1:0]  id_reg_waddr_i;
    logic                        id_long_lat_i;
    logic                        id_fence_i;
    logic                        ex_busy_i;
    logic                        redirect_i;
    logic                        wb_valid_i;
    logic [`REG_ADDR_WIDTH-1:0]  wb_waddr_i;
    logic [`CU_BUS_WIDTH-1:0]    stall_flag_o;
    logic                        issue_o;
    logic [CNT_W-1:0]            pending_cnt_o;
    logic                        sb_err_o;

    modport master (
        output id_inst_valid_i, id_rs1_re_i, id_rs1_raddr_i, id_rs2_re_i,
               id_rs2_raddr_i, id_reg_we_i, id_reg_waddr_i, id_long_lat_i,
               id_fence_i, ex_busy_i, redirect_i, wb_valid_i, wb_waddr_i,
        input  stall_flag_o, issue_o, pending_cnt_o, sb_err_o
    );

    modport slave (
        input  id_inst_valid_i, id_rs1_re_i, id_rs1_raddr_i, id_rs2_re_i,
               id_rs2_raddr_i, id_reg_we_i, id_reg_waddr_i, id_long_lat_i,
               id_fence_i, ex_busy_i, redirect_i, wb_valid_i, wb_waddr_i,
        output stall_flag_o, issue_o, pending_cnt_o, sb_err_o
    );
endinterface

`default_nettype wire

// File: rtl/idu_hazard_ctrl.sv
// ============================================================================
// idu_hazard_ctrl : scoreboard-based stall/flush control for the ID->EX stage
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 4
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif

module idu_hazard_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 2,
    parameter int CNT_W           = 5
) (
    input  logic               clk,
    input  logic               rst,
    idu_hazard_ctrl_if.slave   bus
);
    localparam logic [0:0]       c_ST_RUN     = 1'b0;
    localparam logic [0:0]       c_ST_FLUSH   = 1'b1;
    localparam logic [3:0]       c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MAX        = CNT_W'(MAX_OUTSTANDING);

    logic [0:0]       state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [31:0]      sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [31:0]      w_wb_onehot, w_rd_onehot, w_sb_eff;
    logic             w_wb_hit, w_set, w_raw, w_waw, w_full, w_fence;
    logic             w_flush, w_stall, w_issue;
    logic [CNT_W-1:0] w_cnt_base;

    always_comb begin
        w_wb_onehot = bus.wb_valid_i ? (32'd1 << bus.wb_waddr_i) : 32'd0;
        w_rd_onehot = 32'd1 << bus.id_reg_waddr_i;
        // Same-cycle writeback bypass: a completing register is already free.
        w_sb_eff    = sb_q & ~w_wb_onehot;
        w_wb_hit    = bus.wb_valid_i & sb_q[bus.wb_waddr_i];
        w_cnt_base  = cnt_q - CNT_W'(w_wb_hit);

        w_raw   = (bus.id_rs1_re_i & w_sb_eff[bus.id_rs1_raddr_i])
                | (bus.id_rs2_re_i & w_sb_eff[bus.id_rs2_raddr_i]);
        w_waw   = bus.id_reg_we_i & w_sb_eff[bus.id_reg_waddr_i];
        w_full  = bus.id_long_lat_i & bus.id_reg_we_i
                & (bus.id_reg_waddr_i != '0) & (w_cnt_base == c_MAX);
        w_fence = bus.id_fence_i & (w_cnt_base != '0);

        // Flush dominates; outputs are held quiet while reset is asserted.
        w_flush = ~rst & ((state_q == c_ST_FLUSH) | bus.redirect_i);
        w_stall = ~rst & ~w_flush & bus.id_inst_valid_i
                & (w_raw | w_waw | w_full | w_fence | bus.ex_busy_i);
        w_issue = ~rst & ~w_flush & bus.id_inst_valid_i & ~w_stall;

        w_set   = w_issue & bus.id_long_lat_i & bus.id_reg_we_i
                & (bus.id_reg_waddr_i != '0);

        sb_d  = (sb_q & ~(w_wb_hit ? w_wb_onehot : 32'd0))
              | (w_set ? w_rd_onehot : 32'd0);
        cnt_d = cnt_q + CNT_W'(w_set) - CNT_W'(w_wb_hit);
        err_d = err_q | (bus.wb_valid_i & ~sb_q[bus.wb_waddr_i]);

        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            c_ST_RUN: begin
                if (bus.redirect_i && (c_FLUSH_LOAD != 4'd0)) begin
                    state_d = c_ST_FLUSH;
                    fcnt_d  = c_FLUSH_LOAD;
                end
            end
            default: begin
                if (bus.redirect_i) begin
                    fcnt_d = c_FLUSH_LOAD;
                    if (c_FLUSH_LOAD == 4'd0) state_d = c_ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) state_d = c_ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_RUN;
            fcnt_q  <= 4'd0;
            sb_q    <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.stall_flag_o            = '0;
        bus.stall_flag_o[`CU_STALL] = w_stall;
        bus.stall_flag_o[`CU_FLUSH] = w_flush;
    end

    assign bus.issue_o       = w_issue;
    assign bus.pending_cnt_o = cnt_q;
    assign bus.sb_err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_idu_hazard_ctrl.sv
// ============================================================================
// tb_idu_hazard_ctrl : directed + random checks against a register-set model
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef CU_BUS_WIDTH
`define CU_BUS_WIDTH 4
`endif
`ifndef CU_STALL
`define CU_STALL 0
`endif
`ifndef CU_FLUSH
`define CU_FLUSH 1
`endif

module tb_idu_hazard_ctrl;
    localparam int MAXO = 4;
    localparam int FLC  = 2;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bit   pend [32];
    int   flush_rem;
    bit   err_m;

    idu_hazard_ctrl_if #(.CNT_W(5)) bus();

    idu_hazard_ctrl #(.MAX_OUTSTANDING(MAXO), .FLUSH_CYCLES(FLC), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int npend();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(pend[r]);
        return n;
    endfunction

    function automatic bit busy(input int r);
        return pend[r] && !(bus.wb_valid_i && int'(bus.wb_waddr_i) == r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic inst(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                        input bit we, input int rd, input bit ll, input bit fn);
        bus.id_inst_valid_i = v;
        bus.id_rs1_re_i     = r1e;
        bus.id_rs1_raddr_i  = 5'(r1);
        bus.id_rs2_re_i     = r2e;
        bus.id_rs2_raddr_i  = 5'(r2);
        bus.id_reg_we_i     = we;
        bus.id_reg_waddr_i  = 5'(rd);
        bus.id_long_lat_i   = ll;
        bus.id_fence_i      = fn;
    endtask

    task automatic wb(input bit v, input int a);
        bus.wb_valid_i = v;
        bus.wb_waddr_i = 5'(a);
    endtask

    task automatic tick();
        logic [3:0] ef;
        int  base;
        int  rd;
        bit  hz, flushing, stall, issue;
        #2;
        rd   = int'(bus.id_reg_waddr_i);
        base = npend() - int'(bus.wb_valid_i && pend[bus.wb_waddr_i]);
        hz   = (bus.id_rs1_re_i && busy(int'(bus.id_rs1_raddr_i)))
            || (bus.id_rs2_re_i && busy(int'(bus.id_rs2_raddr_i)))
            || (bus.id_reg_we_i && busy(rd))
            || (bus.id_long_lat_i && bus.id_reg_we_i && rd != 0 && base == MAXO)
            || (bus.id_fence_i && base != 0)
            || bus.ex_busy_i;
        flushing = !rst && (flush_rem > 0 || bus.redirect_i);
        stall    = !rst && !flushing && bus.id_inst_valid_i && hz;
        issue    = !rst && !flushing && bus.id_inst_valid_i && !hz;
        ef = 4'd0;
        ef[`CU_FLUSH] = flushing;
        ef[`CU_STALL] = stall;
        chk("stall_flag", 32'(bus.stall_flag_o), 32'(ef));
        chk("issue", 32'(bus.issue_o), 32'(issue));
        chk("pending_cnt", 32'(bus.pending_cnt_o), 32'(npend()));
        chk("sb_err", 32'(bus.sb_err_o), 32'(err_m));
        @(posedge clk);
        if (rst) begin
            foreach (pend[r]) pend[r] = 1'b0;
            flush_rem = 0;
            err_m     = 1'b0;
        end else begin
            if (bus.wb_valid_i) begin
                if (pend[bus.wb_waddr_i]) pend[bus.wb_waddr_i] = 1'b0;
                else err_m = 1'b1;
            end
            if (issue && bus.id_long_lat_i && bus.id_reg_we_i && rd != 0) pend[rd] = 1'b1;
            if (bus.redirect_i) flush_rem = FLC - 1;
            else if (flush_rem > 0) flush_rem--;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        bus.ex_busy_i  = 1'b0;
        bus.redirect_i = 1'b0;
        foreach (pend[r]) pend[r] = 1'b0;
        flush_rem = 0;
        err_m     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Load-use: stall until the writeback bypass frees x5.
        inst(1, 0, 0, 0, 0, 1, 5, 1, 0); tick();
        inst(1, 1, 5, 0, 0, 1, 8, 0, 0); tick(); tick(); tick();
        wb(1, 5); tick();
        wb(0, 0); inst(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Outstanding limit, relieved by a same-cycle writeback.
        for (int r = 1; r <= 4; r++) begin inst(1, 0, 0, 0, 0, 1, r, 1, 0); tick(); end
        inst(1, 0, 0, 0, 0, 1, 6, 1, 0); tick(); tick();
        wb(1, 2); tick();
        inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (pend[r]) if (pend[r]) begin wb(1, r); tick(); end
        wb(0, 0); tick();

        // Flush length, RAW masked during flush, then extension by a 2nd redirect.
        inst(1, 0, 0, 0, 0, 1, 9, 1, 0); tick();
        inst(1, 1, 9, 0, 0, 0, 0, 0, 0);
        bus.redirect_i = 1'b1; tick();
        bus.redirect_i = 1'b0; tick(); tick();
        bus.redirect_i = 1'b1; tick();
        bus.redirect_i = 1'b0; tick();
        bus.redirect_i = 1'b1; tick();
        bus.redirect_i = 1'b0; tick(); tick();
        wb(1, 9); tick();
        wb(0, 0);

        // Fence drains all pending writebacks.
        inst(1, 0, 0, 0, 0, 1, 10, 1, 0); tick();
        inst(1, 0, 0, 0, 0, 1, 11, 1, 0); tick();
        inst(1, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        wb(1, 10); tick();
        wb(1, 11); tick();
        wb(0, 0); inst(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Spurious writebacks and rd=x0 long-latency ops.
        wb(1, 7); tick();
        wb(1, 0); tick();
        wb(0, 0); inst(1, 0, 0, 0, 0, 1, 0, 1, 0); tick(); tick();

        // Reset during flush with entries pending.
        for (int r = 12; r <= 14; r++) begin inst(1, 0, 0, 0, 0, 1, r, 1, 0); tick(); end
        inst(1, 1, 12, 0, 0, 0, 0, 0, 0);
        bus.redirect_i = 1'b1; tick();
        bus.redirect_i = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; tick(); tick();

        // Randomized traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            int a;
            rst = ($urandom_range(0, 149) == 0);
            inst($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            bus.ex_busy_i  = ($urandom_range(0, 4) == 0);
            bus.redirect_i = ($urandom_range(0, 11) == 0);
            a = $urandom_range(0, 7);
            if ($urandom_range(0, 9) != 0)
                for (int k = 0; k < 8; k++) if (pend[(a + k) % 8]) begin a = (a + k) % 8; break; end
            wb($urandom_range(0, 9) < 4, a);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
